// File: rtl/rv32i_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Build option IFETCH_MISALIGN_CHECK_EN adds the FAULT state for misaligned redirects.
package rv32i_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;
`endif

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered prefetch FIFO: no bypass, flush wins over push/pop, push allowed
// while full when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int               DEPTH       = 2,
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_ENTRY = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_ENTRY;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, prefetch FIFO, redirect/drain.
// Build option IFETCH_MISALIGN_CHECK_EN enables sticky fetch_fault on misaligned redirects.
module instr_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] iaddr,
  input  logic        imem_rvalid,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] pc,
  output logic        fetch_fault
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_e  state_q, state_d, idle_st_s;
  logic [31:0]   fetch_pc_q, fetch_pc_d, iaddr_s, redir_pc_s;
  logic          fault_q, fault_d, run_en_q, run_en_d;
  logic          push_s, pop_s, req_s, full_s, empty_s;
  logic          misalign_s, fault_next_s, space_run_s, space_push_s;
  logic [CW-1:0] count_s;
  logic [63:0]   head_s;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redir_pc_s = redirect_pc;
  assign misalign_s = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign idle_st_s  = fault_next_s ? ST_FAULT : ST_RUN;
`else
  assign redir_pc_s = align_word(redirect_pc);
  assign misalign_s = 1'b0;
  assign idle_st_s  = ST_RUN;
`endif
  assign fault_next_s = fault_q | misalign_s;

  assign pop_s        = !empty_s && if_ready && !redirect_valid;
  // Space checks count the pop (and the push, when a response lands) of this cycle.
  assign space_run_s  = !full_s || pop_s;
  assign space_push_s = (OW'(count_s) + OW'(1) - OW'(pop_s)) < OW'(FIFO_DEPTH);

  // Next-state, request and FIFO control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    run_en_d   = 1'b1;
    push_s     = 1'b0;
    req_s      = 1'b0;
    iaddr_s    = fetch_pc_q;
    if (redirect_valid) begin
      fault_d = fault_next_s;
      if (!misalign_s) fetch_pc_d = redir_pc_s;
    end else begin
      fault_d = fault_q;
    end
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          state_d = idle_st_s;
        end else if (run_en_q && space_run_s) begin
          req_s   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? idle_st_s : ST_DRAIN;
        end else if (imem_rvalid) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          iaddr_s    = fetch_pc_q + 32'd4;
          if (space_push_s) begin
            req_s   = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        state_d = imem_rvalid ? idle_st_s : ST_DRAIN;
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers; run_en_q holds off the first request until one edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      run_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      run_en_q   <= run_en_d;
    end
  end

  fetch_fifo #(
    .DEPTH       (FIFO_DEPTH),
    .WIDTH       (64),
    .RESET_ENTRY ({RESET_PC, NOP_INSTR})
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data ({fetch_pc_q, idata}),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign imem_req    = req_s;
  assign iaddr       = iaddr_s;
  assign if_valid    = !empty_s;
  assign pc          = head_s[63:32];
  assign if_instr    = head_s[31:0];
  assign fetch_fault = fault_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: prefetch buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req, output, 1 bit: one-cycle fetch request pulse to instruction memory.
REQ-006 SHALL have port iaddr, output, 32 bits: fetch address, valid when imem_req=1.
REQ-007 SHALL have port imem_rvalid, input, 1 bit: response strobe for the outstanding request.
REQ-008 SHALL have port idata, input, 32 bits: instruction word, valid when imem_rvalid=1.
REQ-009 SHALL have port redirect_valid, input, 1 bit: taken branch or jump from execute.
REQ-010 SHALL have port redirect_pc, input, 32 bits: target address, valid when redirect_valid=1.
REQ-011 SHALL have port if_valid, output, 1 bit: head instruction available to decode.
REQ-012 SHALL have port if_ready, input, 1 bit: decode accepts the head entry this cycle.
REQ-013 SHALL have port if_instr, output, 32 bits: head instruction word.
REQ-014 SHALL have port pc, output, 32 bits: address of if_instr.
REQ-015 SHALL have port fetch_fault, output, 1 bit: misaligned redirect seen (REQ-033).

Function
REQ-016 SHALL implement states RUN, WAIT, DRAIN and FAULT.
- RUN: no request outstanding.
- WAIT: request outstanding, response wanted.
- DRAIN: request outstanding, response to be discarded.
- FAULT: halted.
REQ-017 SHALL keep at most one imem request outstanding at any time.
REQ-018 SHALL, in RUN, assert imem_req with iaddr=fetch_pc when (FIFO occupancy after this cycle's pop) < FIFO_DEPTH, then enter WAIT.
REQ-019 SHALL, in WAIT, on imem_rvalid push {iaddr_latched, idata} into the FIFO, add 4 to fetch_pc modulo 2^32, and return to RUN.
REQ-020 SHALL allow a new imem_req in the same cycle as the accepting imem_rvalid when REQ-018 space holds, giving back-to-back issue with 1-cycle imem latency.
REQ-021 SHALL assert if_valid starting the cycle after the push; the FIFO is registered with no bypass.
REQ-022 SHALL pop the head when if_valid and if_ready are both 1; if_instr and pc SHALL hold while if_valid=1 and if_ready=0.
REQ-023 SHALL allow push and pop in the same cycle when full; occupancy is unchanged.
REQ-024 SHALL, on redirect_valid, flush the FIFO (if_valid=0 next cycle) and set fetch_pc=redirect_pc.
- From RUN: go to RUN.
- From WAIT: go to DRAIN.
REQ-025 SHALL give redirect_valid priority over a simultaneous if_ready pop and imem_rvalid push; that response SHALL be dropped.
REQ-026 SHALL, in DRAIN, discard the response on imem_rvalid and enter RUN; a redirect while in DRAIN SHALL only update fetch_pc.
REQ-027 SHALL NOT assert imem_req in the cycle redirect_valid=1; the first redirected fetch issues the next cycle from RUN.
REQ-028 SHALL treat imem_rvalid in RUN or FAULT as spurious and ignore it.

Reset
REQ-029 SHALL, while reset=0, asynchronously force:
- state=RUN, fetch_pc=RESET_PC, FIFO empty;
- imem_req=0, if_valid=0, fetch_fault=0;
- iaddr=RESET_PC, pc=RESET_PC, if_instr=32'h0000_0013 (NOP).
REQ-030 SHALL issue its first imem_req, at RESET_PC, in the first rising edge cycle after reset deasserts.
REQ-031 SHALL, on reset mid-transaction, abandon the outstanding request; a later imem_rvalid SHALL be ignored per REQ-028.

Configuration
REQ-032 SHALL use macro IFETCH_MISALIGN_CHECK_EN.
REQ-033 SHALL, with the macro defined, handle redirect_pc[1:0]!=0 as follows:
- flush the FIFO;
- set fetch_fault=1, sticky until reset;
- enter FAULT, or DRAIN then FAULT if a request is outstanding;
- issue no further requests.
REQ-034 SHALL, without the macro, force redirect_pc[1:0] to 2'b00, tie fetch_fault to 0, and omit the FAULT state.

Structure
REQ-035 SHALL place the state enum, the NOP constant 32'h0000_0013 and the RESET_PC default in shared package rv32i_fetch_pkg.
REQ-036 SHALL instantiate one sub-module, fetch_fifo: parameterised depth, 64-bit entries, flush, push/pop, full/empty.

Verification
REQ-037 SHALL verify reset release with imem latency 1 and if_ready=1: imem_req at 0x0, 0x4, 0x8 on consecutive cycles; if_valid/pc=0x0 two cycles after release.
REQ-038 SHALL verify back-pressure: if_ready=0 with FIFO_DEPTH=2 gives exactly 2 entries buffered, imem_req stays 0, and pc holds at 0x0.
REQ-039 SHALL verify redirect to 0x100 during WAIT with latency 3: the stale response is dropped, the next imem_req is at 0x100, and the first pc seen is 0x100.
REQ-040 SHALL verify simultaneous redirect, rvalid and pop: the FIFO is empty next cycle and no entry from the old path ever appears at pc.
REQ-041 SHALL verify, with IFETCH_MISALIGN_CHECK_EN, that redirect to 0x102 gives fetch_fault=1, no further imem_req, and if_valid=0 until reset.
REQ-042 SHALL verify wrap-around: RESET_PC=0xFFFF_FFFC gives a second fetch at 0x0000_0000.
